regfile_wb_arbiter: RTL and testbench

- Shares the register file's WRITE_PORTS write ports among NUM_REQ write-back sources (e.g. alu0, alu1, lsu, mdu).
- Each source uses a valid/ready handshake. Fair round-robin grant.
- Registered outputs drive the regfile wen/waddr/wdata directly.
- Guarantees no two ports write the same register in one cycle, and that writes to x0 never consume a port.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr_multi_grant.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry and write-back request record
package regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int AW         = $clog2(REG_NUM);

  typedef struct packed {
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_multi_grant.sv
// rtl/regfile_wb_arbiter_rr_multi_grant.sv - round-robin multi-port grant with address de-duplication
module rr_multi_grant #(
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2,
  parameter int AW          = 5,
  parameter int IW          = 2
) (
  input  logic [NUM_REQ-1:0]                 valid,
  input  logic [NUM_REQ-1:0][AW-1:0]         waddr,
  input  logic [IW-1:0]                      rr_ptr,
  output logic [WRITE_PORTS-1:0][IW-1:0]     port_idx,
  output logic [WRITE_PORTS-1:0]             port_vld,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [IW-1:0]                      last_idx
);

  logic [WRITE_PORTS-1:0][AW-1:0] port_addr;
  logic                           clash;
  int                             used;
  int                             idx;

  // Walk requesters from rr_ptr, handing out ports in ascending order; x0
  // writes and addresses already claimed this cycle are passed over.
  always_comb begin
    port_idx  = '0;
    port_vld  = '0;
    port_addr = '0;
    grant     = '0;
    last_idx  = rr_ptr;
    clash     = 1'b0;
    used      = 0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[idx] && (waddr[idx] != '0) && (used < WRITE_PORTS)) begin
        clash = 1'b0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if ((p < used) && (port_addr[p] == waddr[idx])) clash = 1'b1;
        end
        if (!clash) begin
          for (int p = 0; p < WRITE_PORTS; p++) begin
            if (p == used) begin
              port_vld[p]  = 1'b1;
              port_idx[p]  = IW'(idx);
              port_addr[p] = waddr[idx];
            end
          end
          grant[idx] = 1'b1;
          last_idx   = IW'(idx);
          used       = used + 1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares regfile write ports among write-back sources
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][AW-1:0]            req_waddr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [WRITE_PORTS-1:0]                rf_wen,
  output logic [WRITE_PORTS-1:0][AW-1:0]        rf_waddr,
  output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] rf_wdata,
  output logic                                  wb_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]                  rr_ptr;
  logic [NUM_REQ-1:0]             nonzero;
  logic [NUM_REQ-1:0]             grant;
  logic [WRITE_PORTS-1:0]         port_vld;
  logic [WRITE_PORTS-1:0][IW-1:0] port_idx;
  logic [IW-1:0]                  last_idx;
  wb_req_t                        sel [WRITE_PORTS];

  rr_multi_grant #(
    .NUM_REQ     (NUM_REQ),
    .WRITE_PORTS (WRITE_PORTS),
    .AW          (AW),
    .IW          (IW)
  ) u_grant (
    .valid    (req_valid),
    .waddr    (req_waddr),
    .rr_ptr   (rr_ptr),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .grant    (grant),
    .last_idx (last_idx)
  );

  // x0 writes are accepted at once and dropped; others only when granted.
  always_comb begin
    nonzero   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nonzero[i]   = (req_waddr[i] != '0);
      req_ready[i] = !rst && req_valid[i] && (!nonzero[i] || grant[i]);
    end
  end

  // Gather the granted request for each port; idle ports carry zeros.
  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      sel[p] = '0;
      if (port_vld[p]) begin
        sel[p].waddr = req_waddr[port_idx[p]];
        sel[p].wdata = req_wdata[port_idx[p]];
      end
    end
  end

  // Output register stage, round-robin pointer and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_busy  <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        rf_wen[p]   <= port_vld[p];
        rf_waddr[p] <= sel[p].waddr;
        rf_wdata[p] <= sel[p].wdata;
      end
      if (|port_vld) begin
        rr_ptr <= (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
      end
      wb_busy <= |(req_valid & nonzero & ~grant);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int N  = 4;
  localparam int WP = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N-1:0]            req_valid = '0;
  logic [N-1:0]            req_ready;
  logic [N-1:0][AW-1:0]    req_waddr = '0;
  logic [N-1:0][DW-1:0]    req_wdata = '0;
  logic [WP-1:0]           rf_wen;
  logic [WP-1:0][AW-1:0]   rf_waddr;
  logic [WP-1:0][DW-1:0]   rf_wdata;
  logic                    wb_busy;

  regfile_wb_arbiter #(.NUM_REQ(N), .WRITE_PORTS(WP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WP-1:0]         wen;
    logic [WP-1:0][AW-1:0] addr;
    logic [WP-1:0][DW-1:0] data;
    logic                  busy;
  } exp_t;

  int      errors = 0;
  int      checks = 0;
  exp_t    exp_q[$];
  bit      primed = 0;
  int      m_ptr = 0;
  logic [N-1:0] last_xfer = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: rank requesters by round-robin order, accept x0 writes,
  // let each distinct nonzero address claim the next port while ports remain.
  exp_t    m_e;
  logic [N-1:0] m_rdy;
  int      m_pick[$];
  bit      m_seen[int];
  always @(negedge clk) begin
    m_e = '{wen: '0, addr: '0, data: '0, busy: 1'b0};
    m_rdy = '0;
    m_pick.delete();
    m_seen.delete();
    if (rst) begin
      m_ptr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int id;
        id = (m_ptr + k) % N;
        if (req_valid[id]) begin
          if (req_waddr[id] == 0) begin
            m_rdy[id] = 1'b1;
          end else if (m_pick.size() < WP && !m_seen.exists(int'(req_waddr[id]))) begin
            m_seen[int'(req_waddr[id])] = 1;
            m_e.wen[m_pick.size()]  = 1'b1;
            m_e.addr[m_pick.size()] = req_waddr[id];
            m_e.data[m_pick.size()] = req_wdata[id];
            m_pick.push_back(id);
            m_rdy[id] = 1'b1;
          end else begin
            m_e.busy = 1'b1;
          end
        end
      end
      if (m_pick.size() > 0) m_ptr = (m_pick[m_pick.size()-1] + 1) % N;
    end
    check("req_ready", 64'(req_ready), 64'(m_rdy));
    last_xfer = m_rdy & req_valid;
    exp_q.push_back(m_e);
    primed = 1;
  end

  // Monitor: compare the registered outputs against the queued expectation.
  exp_t mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() == 0) begin
      if (primed) check("queue_empty", 64'(0), 64'(1));
    end else begin
      mon_e = exp_q.pop_front();
      check("rf_wen",   64'(rf_wen),   64'(mon_e.wen));
      check("rf_waddr", 64'(rf_waddr), 64'(mon_e.addr));
      check("rf_wdata", 64'(rf_wdata), 64'(mon_e.data));
      check("wb_busy",  64'(wb_busy),  64'(mon_e.busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int  n;
  bit  got;

  initial begin
    // Post-reset idle
    step();
    step();
    rst = 1'b0;
    step();
    check("idle_wen", 64'(rf_wen), 64'(0));
    check("idle_busy", 64'(wb_busy), 64'(0));
    step();

    // Full contention
    req_valid = 4'b1111;
    req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    req_wdata = {32'hD, 32'hC, 32'hB, 32'hA};
    step();
    check("cont_c1_wen", 64'(rf_wen), 64'(2'b11));
    check("cont_c1_addr", 64'(rf_waddr), 64'({5'd2, 5'd1}));
    check("cont_c1_busy", 64'(wb_busy), 64'(1));
    step();
    check("cont_c2_addr", 64'(rf_waddr), 64'({5'd4, 5'd3}));
    check("cont_c2_data", 64'(rf_wdata), 64'({32'hD, 32'hC}));
    step();
    do_reset();

    // x0 drop
    req_valid = 4'b0011;
    req_waddr = {5'd0, 5'd0, 5'd5, 5'd0};
    req_wdata = {32'h0, 32'h0, 32'h55, 32'h99};
    step();
    req_valid = '0;
    check("x0_wen", 64'(rf_wen), 64'(2'b01));
    check("x0_addr", 64'(rf_waddr[0]), 64'(5));
    step();
    do_reset();

    // Address collision
    req_valid = 4'b0011;
    req_waddr = {5'd0, 5'd0, 5'd7, 5'd7};
    req_wdata = {32'h0, 32'h0, 32'd22, 32'd11};
    step();
    req_valid = 4'b0010;
    check("coll_c1_wen", 64'(rf_wen), 64'(2'b01));
    check("coll_c1_data", 64'(rf_wdata[0]), 64'(11));
    step();
    req_valid = '0;
    check("coll_c2_wen", 64'(rf_wen), 64'(2'b01));
    check("coll_c2_data", 64'(rf_wdata[0]), 64'(22));
    step();
    do_reset();

    // Fairness: req3 held while req0-2 re-assert every cycle
    req_waddr = {5'd9, 5'd3, 5'd2, 5'd1};
    req_wdata = {32'h33, 32'h22, 32'h11, 32'h00};
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      req_valid = 4'b1111;
      @(negedge clk);
      n++;
      if (req_ready[3]) got = 1;
      step();
    end
    check("fair_latency", 64'(got && n <= N), 64'(1));
    req_valid = 4'b0111;
    @(negedge clk);
    check("fair_wrap", 64'(req_ready), 64'(4'b0011));
    step();
    do_reset();

    // Reset mid-flight
    req_valid = 4'b0001;
    req_waddr = {5'd0, 5'd0, 5'd0, 5'd6};
    req_wdata = {32'h0, 32'h0, 32'h0, 32'h66};
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    step();
    check("rst_wen", 64'(rf_wen), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    step();

    // Randomized traffic with held requests and occasional reset
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_xfer[i]) begin
          req_valid[i] = $urandom_range(0, 1) == 1;
          req_waddr[i] = AW'($urandom_range(0, 7));
          req_wdata[i] = $urandom;
        end
      end
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    step();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
